register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 15 +
 rtl/regfile_read_port.sv | 36 +++
 rtl/register_file.sv | 78 +++++++
 tb/tb_register_file.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared register-file definitions, reused by decode and forwarding logic.
package register_file_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned XZR_IDX    = 31;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

  // True when the index names the hardwired zero register.
  function automatic logic is_xzr(input reg_idx_t idx);
    return idx == reg_idx_t'(XZR_IDX);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, zero-register masking and
// same-cycle write bypass.
module regfile_read_port #(
  parameter int unsigned DATA_WIDTH  = register_file_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = register_file_pkg::ADDR_WIDTH,
  parameter bit          ZERO_REG_EN = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  input  logic                  bypass_en,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  import register_file_pkg::*;

  // The top index is the zero register when enabled.
  localparam logic [ADDR_WIDTH-1:0] ZR_IDX = '1;

  logic is_zr;
  logic hit;

  // Select zero, bypassed write data, or the stored value, in that priority.
  always_comb begin
    is_zr   = ZERO_REG_EN && (rd_idx == ZR_IDX);
    hit     = bypass_en && (wr_idx == rd_idx);
    rd_data = regs[rd_idx];
    if (is_zr) begin
      rd_data = '0;
    end else if (hit) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32-entry general-purpose register file: two combinational read ports,
// one clocked write port, XZR hardwired to zero.
module register_file #(
  parameter int unsigned DATA_WIDTH  = register_file_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = register_file_pkg::ADDR_WIDTH,
  parameter bit          ZERO_REG_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  import register_file_pkg::*;

  localparam int unsigned           DEPTH  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR_IDX = '1;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_ok;
  logic                  bypass_en;

  // Bypass is suppressed while in reset so both ports read zero then.
  assign bypass_en = reg_write && rst_n;

  // Next-state array: apply the enabled write unless it targets XZR.
  always_comb begin
    regs_d = regs_q;
    wr_ok  = reg_write && !(ZERO_REG_EN && (write_register == ZR_IDX));
    if (wr_ok) begin
      regs_d[write_register] = write_data;
    end
  end

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_rd_port_1 (
    .rd_idx   (read_register_1),
    .regs     (regs_q),
    .bypass_en(bypass_en),
    .wr_idx   (write_register),
    .wr_data  (write_data),
    .rd_data  (read_data_1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_rd_port_2 (
    .rd_idx   (read_register_2),
    .regs     (regs_q),
    .bypass_en(bypass_en),
    .wr_idx   (write_register),
    .wr_data  (write_data),
    .rd_data  (read_data_2)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read-port
// values, a monitor pops and compares them when a sample is presented.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic [4:0]  write_register;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] read_data_1;
  logic [63:0] read_data_2;

  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
    string       nm;
  } exp_t;

  exp_t q[$];
  event smp;
  int   checks   = 0;
  int   failures = 0;

  register_file #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (5),
    .ZERO_REG_EN(1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_register_1(read_register_1),
    .read_register_2(read_register_2),
    .write_register (write_register),
    .write_data     (write_data),
    .reg_write      (reg_write),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on each presented sample, pop expectations and compare.
  initial begin
    forever begin
      @(smp);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (read_data_1 !== e.e1) begin
          failures++;
          $display("FAIL %s port1: got %h expected %h", e.nm, read_data_1, e.e1);
        end
        checks++;
        if (read_data_2 !== e.e2) begin
          failures++;
          $display("FAIL %s port2: got %h expected %h", e.nm, read_data_2, e.e2);
        end
      end
    end
  end

  // Drive read indices, settle, queue expectations and present a sample.
  task automatic check_now(input logic [4:0] r1, input logic [4:0] r2,
                           input logic [63:0] e1, input logic [63:0] e2,
                           input string nm);
    exp_t e;
    read_register_1 = r1;
    read_register_2 = r2;
    #1;
    e.e1 = e1;
    e.e2 = e2;
    e.nm = nm;
    q.push_back(e);
    -> smp;
    #1;
  endtask

  task automatic check_sync(input logic [4:0] r1, input logic [4:0] r2,
                            input logic [63:0] e1, input logic [63:0] e2,
                            input string nm);
    @(negedge clk);
    check_now(r1, r2, e1, e2, nm);
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [63:0] data);
    @(negedge clk);
    reg_write      = 1'b1;
    write_register = idx;
    write_data     = data;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    reg_write       = 1'b0;
    write_register  = '0;
    write_data      = '0;
    read_register_1 = '0;
    read_register_2 = '0;

    // Reset state
    #2;
    check_now(5'd0, 5'd15, 64'h0, 64'h0, "reset_0_15");
    check_now(5'd30, 5'd30, 64'h0, 64'h0, "reset_30");
    // Bypass must not leak through while in reset
    reg_write = 1'b1; write_register = 5'd4; write_data = 64'h77;
    check_now(5'd4, 5'd4, 64'h0, 64'h0, "reset_bypass_masked");
    reg_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset clears without a clock edge
    write_reg(5'd5, 64'hAA);
    check_sync(5'd5, 5'd5, 64'hAA, 64'hAA, "x5_written");
    @(negedge clk);
    #1 rst_n = 1'b0;
    check_now(5'd5, 5'd5, 64'h0, 64'h0, "x5_async_clear");
    rst_n = 1'b1;

    // Basic write/read, ports swapped
    write_reg(5'd1, 64'h0123_4567_89AB_CDEF);
    write_reg(5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    check_sync(5'd1, 5'd2, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, "rd_1_2");
    check_sync(5'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, "rd_2_1");

    // Enable gating
    write_reg(5'd3, 64'h1234);
    @(negedge clk);
    reg_write = 1'b0; write_register = 5'd3; write_data = 64'h55;
    @(posedge clk);
    check_sync(5'd3, 5'd1, 64'h1234, 64'h0123_4567_89AB_CDEF, "we_gated_x3");

    // XZR: before and after the edge
    @(negedge clk);
    reg_write = 1'b1; write_register = 5'd31; write_data = 64'hDEAD;
    check_now(5'd31, 5'd31, 64'h0, 64'h0, "xzr_before_edge");
    @(posedge clk);
    #1;
    check_now(5'd31, 5'd31, 64'h0, 64'h0, "xzr_after_edge");
    reg_write = 1'b0;
    check_sync(5'd31, 5'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, "xzr_idle");

    // Bypass on both ports, independent of the other port's index
    write_reg(5'd7, 64'h10);
    check_sync(5'd7, 5'd7, 64'h10, 64'h10, "x7_initial");
    @(negedge clk);
    reg_write = 1'b1; write_register = 5'd7; write_data = 64'h20;
    check_now(5'd7, 5'd7, 64'h20, 64'h20, "bypass_both");
    check_now(5'd7, 5'd3, 64'h20, 64'h1234, "bypass_port1_only");
    check_now(5'd1, 5'd7, 64'h0123_4567_89AB_CDEF, 64'h20, "bypass_port2_only");
    @(posedge clk);
    #1 reg_write = 1'b0;
    check_sync(5'd7, 5'd7, 64'h20, 64'h20, "bypass_committed");

    // Back-to-back writes from a clean state, then full sweep
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      write_reg(5'(i), 64'(i) * 64'h1111);
    end
    for (int i = 0; i < 32; i++) begin
      logic [63:0] e1;
      logic [63:0] e2;
      e1 = (i == 31) ? 64'h0 : 64'(i) * 64'h1111;
      e2 = (i == 0) ? 64'h0 : 64'(31 - i) * 64'h1111;
      check_sync(5'(i), 5'(31 - i), e1, e2, $sformatf("sweep_%0d", i));
    end

    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
